// File: rtl/parity_tx_pkg.sv
// Shared types and helpers for the parity_tx serial transmitter.
package parity_tx_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_e;

  // Start, parity and stop bits wrap every data word.
  localparam int FRAME_OVERHEAD_BITS = 3;

  function automatic int frame_bits(input int data_w);
    return data_w + FRAME_OVERHEAD_BITS;
  endfunction

  // Zero-extension of narrower data does not change the XOR reduction.
  function automatic logic calc_parity(input logic [63:0] data, input logic odd);
    return odd ^ (^data);
  endfunction

endpackage

// File: rtl/parity_tx_baud.sv
// Bit-period tick generator: tick pulses on the last cycle of each bit; held clear while disabled.
module parity_tx_baud #(
  parameter int CLKS_PER_BIT = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  output logic tick
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (!enable || tick) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/parity_tx.sv
// Framed serial transmitter: start, DATA_W bits LSB-first, parity, stop.
// Optional PARITY_TX_ERR_INJECT_EN adds an inject input that inverts one frame's parity bit.
//
// Handshake: load is a request qualified only while busy=0 (state IDLE, which
// includes the done cycle); the accepting edge captures din (and inject).
// There is no backpressure and no queueing -- a load seen while busy is dropped.
module parity_tx
  import parity_tx_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 4,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] din,
`ifdef PARITY_TX_ERR_INJECT_EN
  input  logic              inject,
`endif
  output logic              txout,
  output logic              busy,
  output logic              done,
  output tx_state_e         dbg_state
);

  localparam int BW = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  tx_state_e         state, state_next;
  logic [DATA_W-1:0] shreg, shreg_next;
  logic [BW-1:0]     bit_cnt, bit_cnt_next;
  logic              par_bit, par_next;
  logic              txout_next, busy_next, done_next;
  logic              tick;
  logic              inj_bit;

`ifdef PARITY_TX_ERR_INJECT_EN
  assign inj_bit = inject;
`else
  assign inj_bit = 1'b0;
`endif

  assign dbg_state = state;

  parity_tx_baud #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk   (clk),
    .reset (reset),
    .enable(state != IDLE),
    .tick  (tick)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      par_bit <= 1'b0;
      txout   <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_next;
      shreg   <= shreg_next;
      bit_cnt <= bit_cnt_next;
      par_bit <= par_next;
      txout   <= txout_next;
      busy    <= busy_next;
      done    <= done_next;
    end
  end

  always_comb begin
    state_next   = state;
    shreg_next   = shreg;
    bit_cnt_next = bit_cnt;
    par_next     = par_bit;
    unique case (state)
      IDLE: begin
        if (load) begin
          state_next   = START;
          shreg_next   = din;
          bit_cnt_next = '0;
          par_next     = calc_parity(64'(din), PARITY_ODD != 0) ^ inj_bit;
        end
      end
      START: if (tick) state_next = DATA;
      DATA: begin
        if (tick) begin
          shreg_next = shreg >> 1;
          if (bit_cnt == BW'(DATA_W - 1)) begin
            state_next   = PARITY;
            bit_cnt_next = '0;
          end else begin
            bit_cnt_next = bit_cnt + BW'(1);
          end
        end
      end
      PARITY: if (tick) state_next = STOP;
      STOP:   if (tick) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Outputs are registered, so they are decoded from the upcoming state.
  always_comb begin
    busy_next = (state_next != IDLE);
    done_next = (state == STOP) && tick;
    case (state_next)
      START:   txout_next = 1'b0;
      DATA:    txout_next = shreg_next[0];
      PARITY:  txout_next = par_next;
      default: txout_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_parity_tx.sv
// Directed bench for parity_tx: default, odd-parity and CLKS_PER_BIT=1 instances.
// Build with +define+PARITY_TX_ERR_INJECT_EN to add the parity-inject frames.
module tb_parity_tx;
  import parity_tx_pkg::*;

  logic       clk = 1'b0;
  logic       reset;
  logic       load0, load1, load2;
  logic [7:0] din;
  logic       inject;
  logic       tx0, tx1, tx2;
  logic       busy0, busy1, busy2;
  logic       done0, done1, done2;
  tx_state_e  st0, st1, st2;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  parity_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_ODD(0)) u_dut (
    .clk(clk), .reset(reset), .load(load0), .din(din),
`ifdef PARITY_TX_ERR_INJECT_EN
    .inject(inject),
`endif
    .txout(tx0), .busy(busy0), .done(done0), .dbg_state(st0)
  );

  parity_tx #(.DATA_W(8), .CLKS_PER_BIT(4), .PARITY_ODD(1)) u_odd (
    .clk(clk), .reset(reset), .load(load1), .din(din),
`ifdef PARITY_TX_ERR_INJECT_EN
    .inject(1'b0),
`endif
    .txout(tx1), .busy(busy1), .done(done1), .dbg_state(st1)
  );

  parity_tx #(.DATA_W(8), .CLKS_PER_BIT(1), .PARITY_ODD(0)) u_fast (
    .clk(clk), .reset(reset), .load(load2), .din(din),
`ifdef PARITY_TX_ERR_INJECT_EN
    .inject(1'b0),
`endif
    .txout(tx2), .busy(busy2), .done(done2), .dbg_state(st2)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic tx_of(input int s);
    case (s)
      1: return tx1;
      2: return tx2;
      default: return tx0;
    endcase
  endfunction

  function automatic logic busy_of(input int s);
    case (s)
      1: return busy1;
      2: return busy2;
      default: return busy0;
    endcase
  endfunction

  function automatic logic done_of(input int s);
    case (s)
      1: return done1;
      2: return done2;
      default: return done0;
    endcase
  endfunction

  task automatic set_load(input int s, input logic v);
    case (s)
      1: load1 = v;
      2: load2 = v;
      default: load0 = v;
    endcase
  endtask

  // Called at a negedge: request a frame, return at the first negedge after acceptance.
  task automatic start_frame(input int s, input logic [7:0] d);
    din = d;
    set_load(s, 1'b1);
    @(negedge clk);
    set_load(s, 1'b0);
  endtask

  // Entered at the first negedge of a frame; returns at the negedge showing done.
  task automatic expect_frame(input int s, input logic [7:0] data, input logic exp_par,
                              input int cpb, input int pulse_cyc, input string tag);
    logic exp_tx;
    int   n;
    n = 0;
    for (int b = 0; b < 11; b++) begin
      if (b == 0)      exp_tx = 1'b0;
      else if (b <= 8) exp_tx = data[b-1];
      else if (b == 9) exp_tx = exp_par;
      else             exp_tx = 1'b1;
      for (int c = 0; c < cpb; c++) begin
        check($sformatf("%s_tx_bit%0d_c%0d", tag, b, c), 32'(tx_of(s)), 32'(exp_tx));
        check($sformatf("%s_busy_n%0d", tag, n), 32'(busy_of(s)), 32'd1);
        check($sformatf("%s_nodone_n%0d", tag, n), 32'(done_of(s)), 32'd0);
        if (pulse_cyc >= 0 && n == pulse_cyc)     set_load(s, 1'b1);
        if (pulse_cyc >= 0 && n == pulse_cyc + 1) set_load(s, 1'b0);
        n++;
        @(negedge clk);
      end
    end
    check({tag, "_done"}, 32'(done_of(s)), 32'd1);
    check({tag, "_done_busy"}, 32'(busy_of(s)), 32'd0);
    check({tag, "_done_tx"}, 32'(tx_of(s)), 32'd1);
  endtask

  task automatic expect_idle(input int s, input int cycles, input string tag);
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      check($sformatf("%s_tx_%0d", tag, i), 32'(tx_of(s)), 32'd1);
      check($sformatf("%s_busy_%0d", tag, i), 32'(busy_of(s)), 32'd0);
      check($sformatf("%s_done_%0d", tag, i), 32'(done_of(s)), 32'd0);
    end
  endtask

  initial begin
    reset  = 1'b1;
    load0  = 1'b0;
    load1  = 1'b0;
    load2  = 1'b0;
    din    = 8'h00;
    inject = 1'b0;
    #2;
    check("rst_tx", 32'(tx0), 32'd1);
    check("rst_busy", 32'(busy0), 32'd0);
    check("rst_done", 32'(done0), 32'd0);
    check("rst_state", 32'(st0), 32'(IDLE));
    check("rst_odd_state", 32'(st1), 32'(IDLE));
    check("rst_fast_state", 32'(st2), 32'(IDLE));
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;

    // Idle with no load.
    expect_idle(0, 20, "idle");

    // 8'h09 even: bits 1,0,0,1,0,0,0,0 parity 0; a load pulse mid-frame is dropped.
    start_frame(0, 8'h09);
    expect_frame(0, 8'h09, 1'b0, 4, 20, "f09");
    expect_idle(0, 10, "f09_after");

    // Parity variants.
    start_frame(1, 8'h09);
    expect_frame(1, 8'h09, 1'b1, 4, -1, "odd09");
    start_frame(0, 8'h07);
    expect_frame(0, 8'h07, 1'b1, 4, -1, "f07");
    @(negedge clk);
    start_frame(0, 8'hFF);
    expect_frame(0, 8'hFF, 1'b0, 4, -1, "fFF");
    @(negedge clk);

    // Load held high: A5 then 3C back-to-back; din change mid-frame must not leak.
    din   = 8'hA5;
    load0 = 1'b1;
    @(negedge clk);
    din = 8'h3C;
    expect_frame(0, 8'hA5, 1'b0, 4, -1, "b2b_a5");
    @(negedge clk);
    load0 = 1'b0;
    expect_frame(0, 8'h3C, 1'b0, 4, -1, "b2b_3c");
    expect_idle(0, 8, "b2b_after");

    // Reset at cycle 10 of a frame, then a clean frame.
    start_frame(0, 8'h55);
    repeat (9) @(negedge clk);
    check("mid_busy_before_rst", 32'(busy0), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("mid_rst_tx", 32'(tx0), 32'd1);
    check("mid_rst_busy", 32'(busy0), 32'd0);
    check("mid_rst_done", 32'(done0), 32'd0);
    check("mid_rst_state", 32'(st0), 32'(IDLE));
    @(negedge clk);
    reset = 1'b0;
    expect_idle(0, 50, "post_rst");
    start_frame(0, 8'h01);
    expect_frame(0, 8'h01, 1'b1, 4, -1, "clean01");

    // One cycle per bit: 8'h80 gives 0, 0 x7, 1, parity 1, stop 1.
    @(negedge clk);
    start_frame(2, 8'h80);
    expect_frame(2, 8'h80, 1'b1, 1, -1, "fast80");
    expect_idle(2, 4, "fast_after");

`ifdef PARITY_TX_ERR_INJECT_EN
    // Inverted parity for one frame only.
    @(negedge clk);
    inject = 1'b1;
    start_frame(0, 8'h09);
    inject = 1'b0;
    expect_frame(0, 8'h09, 1'b1, 4, -1, "inj09");
    @(negedge clk);
    start_frame(0, 8'h09);
    expect_frame(0, 8'h09, 1'b0, 4, -1, "noinj09");
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
